// File: rtl/fifo_ms_pkg.sv
// Shared types and width helpers for the multi-stream tagged FIFO.
package fifo_ms_pkg;

    localparam int STAT_CNT_W = 16;

    typedef struct packed {
        logic                  full;
        logic                  empty;
        logic                  almost_full;
        logic [STAT_CNT_W-1:0] count;
    } lane_status_t;

    function automatic int tag_width(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ms_lane.sv
// One first-word-fall-through queue lane: storage, pointers, occupancy and error pulses.
module fifo_ms_lane
    import fifo_ms_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AFULL_TH   = DEPTH - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] head,
    output lane_status_t          status,
    output logic                  overflow_pulse,
    output logic                  underflow_pulse
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH  = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] rp_r;
    logic [ADDR_WIDTH-1:0] wp_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_ok_s;
    logic                  rd_ok_s;

    // Qualify push/pop against occupancy; flush masks both and suppresses error pulses
    always_comb begin
        full_s          = (cnt_r == CNT_WIDTH'(DEPTH));
        empty_s         = (cnt_r == {CNT_WIDTH{1'b0}});
        wr_ok_s         = push & ~full_s & ~flush;
        rd_ok_s         = pop & ~empty_s & ~flush;
        overflow_pulse  = push & full_s & ~flush;
        underflow_pulse = pop & empty_s & ~flush;
        head            = mem_r[rp_r];
        status.full        = full_s;
        status.empty       = empty_s;
        status.almost_full = (cnt_r >= CNT_WIDTH'(AFULL_TH));
        status.count       = STAT_CNT_W'(cnt_r);
    end

    // Payload storage, deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wp_r] <= push_data;
        end
    end

    // Pointer and occupancy state; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rp_r  <= {ADDR_WIDTH{1'b0}};
            wp_r  <= {ADDR_WIDTH{1'b0}};
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (flush) begin
            rp_r  <= {ADDR_WIDTH{1'b0}};
            wp_r  <= {ADDR_WIDTH{1'b0}};
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wp_r <= wp_r + ADDR_WIDTH'(1);
            end
            if (rd_ok_s) begin
                rp_r <= rp_r + ADDR_WIDTH'(1);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   cnt_r <= cnt_r + CNT_WIDTH'(1);
                2'b01:   cnt_r <= cnt_r - CNT_WIDTH'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/fifo_ms_flow.sv
// Multi-stream tagged FIFO: one tagged write port fanned out to FLUX independent FWFT read lanes.
module fifo_ms_flow
    import fifo_ms_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int FLUX       = 4,
    parameter int AFULL_TH   = DEPTH - 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_valid,
    output logic                                  wr_ready,
    input  logic [tag_width(FLUX)+DATA_WIDTH-1:0] wr_data,
    input  logic [FLUX-1:0]                       rd_en,
    output logic [FLUX-1:0]                       rd_valid,
    output logic [FLUX*DATA_WIDTH-1:0]            rd_data,
    input  logic [FLUX-1:0]                       flush,
    output logic [FLUX-1:0]                       full,
    output logic [FLUX-1:0]                       empty,
    output logic [FLUX-1:0]                       almost_full,
    output logic [FLUX*cnt_width(DEPTH)-1:0]      count,
    output logic [FLUX-1:0]                       overflow,
    output logic [FLUX-1:0]                       underflow,
    output logic                                  bad_tag,
    input  logic                                  err_clr
);
    localparam int TAG_WIDTH = tag_width(FLUX);
    localparam int CNT_WIDTH = cnt_width(DEPTH);

    logic [TAG_WIDTH-1:0]  tag_s;
    logic [DATA_WIDTH-1:0] payload_s;
    logic [FLUX-1:0]       sel_s;
    logic [FLUX-1:0]       full_s;
    logic [FLUX-1:0]       ovf_pulse_s;
    logic [FLUX-1:0]       udf_pulse_s;
    logic                  bad_set_s;
    logic [FLUX-1:0]       overflow_r;
    logic [FLUX-1:0]       underflow_r;
    logic                  bad_tag_r;
    lane_status_t          lane_stat_s [FLUX];

    // Tag decode: one-hot lane select, all-zero for an out-of-range tag (which is then always ready)
    always_comb begin
        tag_s     = wr_data[TAG_WIDTH+DATA_WIDTH-1 -: TAG_WIDTH];
        payload_s = wr_data[DATA_WIDTH-1:0];
        for (int f = 0; f < FLUX; f++) begin
            sel_s[f] = (int'(tag_s) == f);
        end
        bad_set_s = wr_valid & ~(|sel_s);
        wr_ready  = ~(|(sel_s & full_s));
    end

    for (genvar f = 0; f < FLUX; f++) begin : g_lane
        fifo_ms_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .AFULL_TH   (AFULL_TH)
        ) u_lane (
            .clk             (clk),
            .rst             (rst),
            .push            (wr_valid & sel_s[f]),
            .push_data       (payload_s),
            .pop             (rd_en[f]),
            .flush           (flush[f]),
            .head            (rd_data[f*DATA_WIDTH +: DATA_WIDTH]),
            .status          (lane_stat_s[f]),
            .overflow_pulse  (ovf_pulse_s[f]),
            .underflow_pulse (udf_pulse_s[f])
        );

        assign full_s[f]                      = lane_stat_s[f].full;
        assign full[f]                        = lane_stat_s[f].full;
        assign empty[f]                       = lane_stat_s[f].empty;
        assign rd_valid[f]                    = ~lane_stat_s[f].empty;
        assign almost_full[f]                 = lane_stat_s[f].almost_full;
        assign count[f*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(lane_stat_s[f].count);
    end

    // Sticky error flags: a new set condition wins over err_clr in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r  <= {FLUX{1'b0}};
            underflow_r <= {FLUX{1'b0}};
            bad_tag_r   <= 1'b0;
        end else begin
            overflow_r  <= (overflow_r & ~{FLUX{err_clr}}) | ovf_pulse_s;
            underflow_r <= (underflow_r & ~{FLUX{err_clr}}) | udf_pulse_s;
            bad_tag_r   <= (bad_tag_r & ~err_clr) | bad_set_s;
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign bad_tag   = bad_tag_r;

endmodule

// File: tb/tb_fifo_ms_flow.sv
// Randomised and directed bench for fifo_ms_flow against a queue-based reference model.
module tb_fifo_ms_flow;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int FLUX  = 3;
    localparam int AFT   = 6;
    localparam int TW    = 2;
    localparam int CW    = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_valid;
    logic                wr_ready;
    logic [TW+DW-1:0]    wr_data;
    logic [FLUX-1:0]     rd_en;
    logic [FLUX-1:0]     rd_valid;
    logic [FLUX*DW-1:0]  rd_data;
    logic [FLUX-1:0]     flush;
    logic [FLUX-1:0]     full;
    logic [FLUX-1:0]     empty;
    logic [FLUX-1:0]     almost_full;
    logic [FLUX*CW-1:0]  count;
    logic [FLUX-1:0]     overflow;
    logic [FLUX-1:0]     underflow;
    logic                bad_tag;
    logic                err_clr;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0]   q [FLUX][$];
    logic [FLUX-1:0] m_ovf;
    logic [FLUX-1:0] m_udf;
    logic            m_bad;

    fifo_ms_flow #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .FLUX       (FLUX),
        .AFULL_TH   (AFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .flush       (flush),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .bad_tag     (bad_tag),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int f = 0; f < FLUX; f++) q[f].delete();
        m_ovf = 3'b000;
        m_udf = 3'b000;
        m_bad = 1'b0;
    endtask

    task automatic check_all();
        int n;
        int t;
        logic exp_rdy;
        for (int f = 0; f < FLUX; f++) begin
            n = q[f].size();
            check_val($sformatf("count%0d", f), 32'(count[f*CW +: CW]), 32'(n));
            check_val($sformatf("rd_valid%0d", f), 32'(rd_valid[f]), 32'(n > 0));
            if (n > 0) check_val($sformatf("rd_data%0d", f), 32'(rd_data[f*DW +: DW]), 32'(q[f][0]));
            check_val($sformatf("full%0d", f), 32'(full[f]), 32'(n == DEPTH));
            check_val($sformatf("empty%0d", f), 32'(empty[f]), 32'(n == 0));
            check_val($sformatf("afull%0d", f), 32'(almost_full[f]), 32'(n >= AFT));
            check_val($sformatf("overflow%0d", f), 32'(overflow[f]), 32'(m_ovf[f]));
            check_val($sformatf("underflow%0d", f), 32'(underflow[f]), 32'(m_udf[f]));
        end
        check_val("bad_tag", 32'(bad_tag), 32'(m_bad));
        t = int'(wr_data[TW+DW-1 -: TW]);
        if (t < FLUX) exp_rdy = (q[t].size() < DEPTH);
        else          exp_rdy = 1'b1;
        check_val("wr_ready", 32'(wr_ready), 32'(exp_rdy));
    endtask

    task automatic model_update(input logic wv, input logic [TW-1:0] tg, input logic [DW-1:0] pl,
                                input logic [FLUX-1:0] re, input logic [FLUX-1:0] fl, input logic ec);
        logic [FLUX-1:0] so;
        logic [FLUX-1:0] su;
        logic            sb;
        int              n;
        logic            hit;
        so = 3'b000;
        su = 3'b000;
        sb = wv && (int'(tg) >= FLUX);
        for (int f = 0; f < FLUX; f++) begin
            n   = q[f].size();
            hit = wv && (int'(tg) == f);
            if (fl[f]) begin
                q[f].delete();
            end else begin
                if (hit && n == DEPTH) so[f] = 1'b1;
                if (re[f] && n == 0)   su[f] = 1'b1;
                if (re[f] && n > 0)    void'(q[f].pop_front());
                if (hit && n < DEPTH)  q[f].push_back(pl);
            end
        end
        if (ec) begin
            m_ovf = 3'b000;
            m_udf = 3'b000;
            m_bad = 1'b0;
        end
        m_ovf = m_ovf | so;
        m_udf = m_udf | su;
        m_bad = m_bad | sb;
    endtask

    task automatic step(input logic wv, input logic [TW-1:0] tg, input logic [DW-1:0] pl,
                        input logic [FLUX-1:0] re, input logic [FLUX-1:0] fl, input logic ec);
        wr_valid = wv;
        wr_data  = {tg, pl};
        rd_en    = re;
        flush    = fl;
        err_clr  = ec;
        #1;
        check_all();
        @(posedge clk);
        model_update(wv, tg, pl, re, fl, ec);
        @(negedge clk);
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        wr_data  = 10'd0;
        rd_en    = 3'b000;
        flush    = 3'b000;
        err_clr  = 1'b0;
    endtask

    initial begin
        logic [TW-1:0] tg;
        logic [FLUX-1:0] re;
        logic [FLUX-1:0] fl;
        rst = 1'b0;
        idle();
        model_reset();
        #2;
        check_all();
        check_val("rst_empty", 32'(empty), 32'(3'b111));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Tagged writes land in their own lanes
        step(1'b1, 2'd0, 8'hA1, 3'b000, 3'b000, 1'b0);
        step(1'b1, 2'd2, 8'hB2, 3'b000, 3'b000, 1'b0);
        step(1'b1, 2'd0, 8'hA3, 3'b000, 3'b000, 1'b0);
        check_val("t2_counts", 32'(count), 32'({4'd1, 4'd0, 4'd2}));
        check_val("t2_lane0_head", 32'(rd_data[7:0]), 32'(8'hA1));
        check_val("t2_lane2_head", 32'(rd_data[23:16]), 32'(8'hB2));
        step(1'b0, 2'd0, 8'h00, 3'b001, 3'b000, 1'b0);
        check_val("t2_lane0_next", 32'(rd_data[7:0]), 32'(8'hA3));
        step(1'b0, 2'd0, 8'h00, 3'b101, 3'b000, 1'b0);

        // Fill lane 1, overflow it, then wrap its pointers
        for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd1, 8'(8'h10 + i), 3'b000, 3'b000, 1'b0);
        check_val("t3_full1", 32'(full[1]), 32'(1'b1));
        step(1'b1, 2'd1, 8'hEE, 3'b000, 3'b000, 1'b0);
        check_val("t3_ovf1", 32'(overflow[1]), 32'(1'b1));
        check_val("t3_count1", 32'(count[7:4]), 32'(4'd8));
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 8'h00, 3'b010, 3'b000, 1'b0);
        check_val("t3_head_after3", 32'(rd_data[15:8]), 32'(8'h13));
        for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 8'(8'h20 + i), 3'b000, 3'b000, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 2'd0, 8'h00, 3'b010, 3'b000, 1'b0);

        // Simultaneous push and pop on a non-empty lane
        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 8'(8'h40 + i), 3'b000, 3'b000, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 8'(8'h50 + i), 3'b001, 3'b000, 1'b0);
        check_val("t4_count0", 32'(count[3:0]), 32'(4'd4));
        check_val("t4_head0", 32'(rd_data[7:0]), 32'(8'h51));

        // Underflow and err_clr priority
        step(1'b0, 2'd0, 8'h00, 3'b101, 3'b000, 1'b0);
        check_val("t5_udf2", 32'(underflow[2]), 32'(1'b1));
        step(1'b0, 2'd0, 8'h00, 3'b100, 3'b000, 1'b1);
        check_val("t5_udf2_sticky", 32'(underflow[2]), 32'(1'b1));
        step(1'b0, 2'd0, 8'h00, 3'b000, 3'b000, 1'b1);
        check_val("t5_cleared", 32'({overflow, underflow}), 32'(6'd0));

        // Illegal tag, and flush overriding a same-cycle write and read
        step(1'b1, 2'd3, 8'h55, 3'b000, 3'b000, 1'b0);
        check_val("t6_bad_tag", 32'(bad_tag), 32'(1'b1));
        step(1'b1, 2'd0, 8'h66, 3'b001, 3'b001, 1'b0);
        check_val("t6_flush_cnt0", 32'(count[3:0]), 32'(4'd0));
        check_val("t6_flush_flags", 32'({overflow[0], underflow[0]}), 32'(2'b00));

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 8'(8'h70 + i), 3'b000, 3'b000, 1'b0);
        step(1'b0, 2'd0, 8'h00, 3'b001, 3'b000, 1'b0);
        idle();
        rst = 1'b0;
        #1;
        model_reset();
        check_val("t1_count", 32'(count), 32'(12'd0));
        check_val("t1_empty", 32'(empty), 32'(3'b111));
        check_val("t1_flags", 32'({overflow, underflow, bad_tag}), 32'(7'd0));
        check_all();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomised traffic, alternating between read-heavy and write-heavy phases
        for (int i = 0; i < 1200; i++) begin
            tg = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ((i / 100) % 2 == 0) re = 3'($urandom) & 3'($urandom) & 3'($urandom);
            else                    re = 3'($urandom);
            for (int f = 0; f < FLUX; f++) fl[f] = ($urandom_range(0, 24) == 0);
            step($urandom_range(0, 3) != 0, tg, 8'($urandom), re, fl, $urandom_range(0, 29) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
